// File: rtl/maxpool_2x2_stream.sv
// maxpool_2x2_stream: streaming 2x2 stride-2 max pooling over a raster-order IFM_SIZE x IFM_SIZE map
// Ports: clk; reset (async, active-low); start (arm/abort pulse); data_in/data_in_valid (input pixel);
//        data_out/data_out_valid (registered pooled pixel + strobe); frame_done (last pooled pixel); busy (RUN)
module maxpool_2x2_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int ARITH_TYPE = 0,
  parameter int IFM_SIZE   = 10,
  parameter int COL_BITS   = $clog2(IFM_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic                  frame_done,
  output logic                  busy
);
  localparam int LB_BITS = COL_BITS > 1 ? COL_BITS - 1 : 1;
  localparam logic [COL_BITS-1:0] LAST = COL_BITS'(IFM_SIZE - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [COL_BITS-1:0] row, col;
  logic [DATA_WIDTH-1:0] h_reg, h_max, win;
  logic [DATA_WIDTH-1:0] lb [2**LB_BITS];
  logic [LB_BITS-1:0] lb_idx;
  logic last_col, last_px, consume;
  // Tie keeps a, the earlier-arriving operand; float compare treats +0 and -0 as equal.
  function automatic logic [DATA_WIDTH-1:0] max2(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    logic b_gt;
    if (ARITH_TYPE == 1) b_gt = $signed(b) > $signed(a);
    else if (a[DATA_WIDTH-2:0] == '0 && b[DATA_WIDTH-2:0] == '0) b_gt = 1'b0;
    else if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) b_gt = !b[DATA_WIDTH-1];
    else if (!a[DATA_WIDTH-1]) b_gt = b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0];
    else b_gt = b[DATA_WIDTH-2:0] < a[DATA_WIDTH-2:0];
    return b_gt ? b : a;
  endfunction
  assign last_col = col == LAST;
  assign last_px  = last_col && row == LAST;
  // start normally discards a coincident pixel, except the map's final pixel, which still completes the frame
  assign consume  = state == RUN && data_in_valid && (!start || last_px);
  assign lb_idx   = LB_BITS'(col >> 1);
  assign h_max    = max2(h_reg, data_in);
  assign win      = max2(lb[lb_idx], h_max);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      row            <= '0;
      col            <= '0;
      h_reg          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_out_valid <= consume && row[0] && col[0];
      frame_done     <= consume && last_px;
      if (consume && !col[0]) h_reg <= data_in;
      if (consume && row[0] && col[0]) data_out <= win;
      if (start) begin
        state <= RUN;
        busy  <= 1'b1;
        row   <= '0;
        col   <= '0;
      end else if (consume) begin
        col   <= last_col ? '0 : col + COL_BITS'(1);
        row   <= last_px ? '0 : row + COL_BITS'(last_col);
        state <= last_px ? IDLE : RUN;
        busy  <= !last_px;
      end
    end
  end
  // Line buffer holds even-row pair maxima; written only on even rows, read only on odd rows.
  always_ff @(posedge clk) begin
    if (consume && !row[0] && col[0]) lb[lb_idx] <= h_max;
  end
endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// tb_maxpool_2x2_stream: self-checking bench for maxpool_2x2_stream
module tb_maxpool_2x2_stream;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  logic a_start = 0, a_valid = 0, b_start = 0, b_valid = 0, c_start = 0, c_valid = 0;
  logic [31:0] a_in = 0, b_in = 0, c_in = 0, a_out, b_out, c_out;
  logic a_ov, a_fd, a_busy, b_ov, b_fd, b_busy, c_ov, c_fd, c_busy;
  maxpool_2x2_stream #(.DATA_WIDTH(32), .ARITH_TYPE(1), .IFM_SIZE(4)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .data_in(a_in), .data_in_valid(a_valid),
    .data_out(a_out), .data_out_valid(a_ov), .frame_done(a_fd), .busy(a_busy));
  maxpool_2x2_stream #(.DATA_WIDTH(32), .ARITH_TYPE(0), .IFM_SIZE(2)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .data_in(b_in), .data_in_valid(b_valid),
    .data_out(b_out), .data_out_valid(b_ov), .frame_done(b_fd), .busy(b_busy));
  maxpool_2x2_stream #(.DATA_WIDTH(32), .ARITH_TYPE(0), .IFM_SIZE(10)) dut_c (
    .clk(clk), .reset(reset), .start(c_start), .data_in(c_in), .data_in_valid(c_valid),
    .data_out(c_out), .data_out_valid(c_ov), .frame_done(c_fd), .busy(c_busy));
  int total = 0, bad = 0;
  logic [31:0] qa[$], qc[$], pxq[$], exp_q[$], exp1[$];
  int fda = 0, fdc = 0;
  always @(negedge clk) begin
    if (a_ov) qa.push_back(a_out);
    if (a_fd) fda++;
    if (c_ov) qc.push_back(c_out);
    if (c_fd) fdc++;
  end
  typedef struct {
    logic [31:0] p [4];
    int          gap;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [6];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Ordering key: numeric value for fixed point; sign-magnitude value for float, with -0 == +0.
  function automatic longint key(input logic [31:0] x, input bit fx);
    if (fx) return longint'($signed(x));
    if (x[30:0] == 0) return 0;
    return x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
  endfunction
  function automatic logic [31:0] mx(input logic [31:0] a, input logic [31:0] b, input bit fx);
    return key(b, fx) > key(a, fx) ? b : a;
  endfunction
  task automatic build_exp(input int n, input bit fx);
    exp_q.delete();
    for (int r = 0; r < n; r += 2)
      for (int c = 0; c < n; c += 2)
        exp_q.push_back(mx(mx(pxq[r*n+c], pxq[r*n+c+1], fx), mx(pxq[(r+1)*n+c], pxq[(r+1)*n+c+1], fx), fx));
  endtask
  function automatic logic [31:0] rnd_px(input bit fx);
    logic [31:0] pool [4];
    pool = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000};
    if (fx) return $urandom_range(0, 1) ? $urandom_range(0, 8) - 4 : $urandom;
    return $urandom_range(0, 2) == 0 ? pool[$urandom_range(0, 3)] : $urandom;
  endfunction
  task automatic drive_a(input int first, input int cnt, input bit gaps);
    for (int i = first; i < first + cnt; i++) begin
      while (gaps && $urandom_range(0, 1) == 0) begin
        a_valid = 0;
        a_in = $urandom;
        tick();
      end
      a_in = pxq[i];
      a_valid = 1;
      tick();
    end
    a_valid = 0;
  endtask
  initial begin
    tbl[0] = '{'{32'hC000_0000, 32'hBF80_0000, 32'hC040_0000, 32'hC080_0000}, 0, 32'hBF80_0000};
    tbl[1] = '{'{32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000}, 0, 32'h8000_0000};
    tbl[2] = '{'{32'h3F80_0000, 32'hBF80_0000, 32'hC000_0000, 32'h4000_0000}, 2, 32'h4000_0000};
    tbl[3] = '{'{32'h0000_0000, 32'h8000_0000, 32'hBF80_0000, 32'h8000_0000}, 1, 32'h0000_0000};
    tbl[4] = '{'{32'h4120_0000, 32'h40A0_0000, 32'h41A0_0000, 32'h3F00_0000}, 0, 32'h41A0_0000};
    tbl[5] = '{'{32'hBF00_0000, 32'h3F00_0000, 32'h8000_0000, 32'h0000_0000}, 3, 32'h3F00_0000};
    repeat (3) tick();
    reset = 1;
    tick();
    chk("rst_data_out", a_out, 0);
    chk("rst_valid", 32'(a_ov), 0);
    chk("rst_frame_done", 32'(a_fd), 0);
    chk("rst_busy", 32'(a_busy), 0);
    // valid while idle is ignored
    a_in = 32'h55;
    a_valid = 1;
    repeat (3) tick();
    a_valid = 0;
    tick();
    chk("idle_outputs", 32'(qa.size()), 0);
    chk("idle_busy", 32'(a_busy), 0);
    // 0..15 on a 4x4 signed map
    a_start = 1;
    tick();
    a_start = 0;
    chk("start_busy", 32'(a_busy), 1);
    for (int i = 0; i < 16; i++) begin
      a_in = i;
      a_valid = 1;
      tick();
      chk($sformatf("seq_valid[%0d]", i), 32'(a_ov), 32'(i == 5 || i == 7 || i == 13 || i == 15));
      if (a_ov) chk($sformatf("seq_data[%0d]", i), a_out, i);
      chk($sformatf("seq_done[%0d]", i), 32'(a_fd), 32'(i == 15));
      chk($sformatf("seq_busy[%0d]", i), 32'(a_busy), 32'(i != 15));
    end
    a_valid = 0;
    tick();
    chk("strobe_drops", 32'(a_ov), 0);
    chk("data_holds", a_out, 15);
    chk("done_drops", 32'(a_fd), 0);
    // float windows on a 2x2 map
    for (int v = 0; v < 6; v++) begin
      b_start = 1;
      tick();
      b_start = 0;
      for (int k = 0; k < 4; k++) begin
        b_in = tbl[v].p[k];
        b_valid = 1;
        tick();
        b_valid = 0;
        if (k < 3) repeat (tbl[v].gap) tick();
      end
      chk($sformatf("tbl_valid[%0d]", v), 32'(b_ov), 1);
      chk($sformatf("tbl_data[%0d]", v), b_out, tbl[v].exp);
      chk($sformatf("tbl_done[%0d]", v), 32'(b_fd), 1);
      chk($sformatf("tbl_busy[%0d]", v), 32'(b_busy), 0);
      tick();
    end
    // abort after 7 pixels; start coincident with a valid pixel discards it
    a_start = 1;
    tick();
    a_start = 0;
    pxq.delete();
    for (int i = 0; i < 16; i++) pxq.push_back(rnd_px(1));
    drive_a(0, 7, 0);
    a_start = 1;
    a_valid = 1;
    a_in = 32'h7FFF_FFFF;
    tick();
    a_start = 0;
    a_valid = 0;
    qa.delete();
    fda = 0;
    pxq.delete();
    for (int i = 0; i < 16; i++) pxq.push_back(rnd_px(1));
    build_exp(4, 1);
    drive_a(0, 16, 1);
    repeat (4) tick();
    chk("abort_count", 32'(qa.size()), 4);
    for (int w = 0; w < 4; w++) chk($sformatf("abort_data[%0d]", w), qa[w], exp_q[w]);
    chk("abort_done", 32'(fda), 1);
    // start on the final pixel re-arms while still finishing the frame
    qa.delete();
    fda = 0;
    a_start = 1;
    tick();
    a_start = 0;
    pxq.delete();
    for (int i = 0; i < 16; i++) pxq.push_back(rnd_px(1));
    build_exp(4, 1);
    exp1 = exp_q;
    drive_a(0, 15, 0);
    a_in = pxq[15];
    a_valid = 1;
    a_start = 1;
    tick();
    a_start = 0;
    a_valid = 0;
    chk("rearm_done", 32'(a_fd), 1);
    chk("rearm_valid", 32'(a_ov), 1);
    chk("rearm_data", a_out, exp1[3]);
    chk("rearm_busy", 32'(a_busy), 1);
    pxq.delete();
    for (int i = 0; i < 16; i++) pxq.push_back(rnd_px(1));
    build_exp(4, 1);
    drive_a(0, 16, 1);
    repeat (3) tick();
    chk("rearm_count", 32'(qa.size()), 8);
    for (int w = 0; w < 4; w++) chk($sformatf("rearm_map1[%0d]", w), qa[w], exp1[w]);
    for (int w = 0; w < 4; w++) chk($sformatf("rearm_map2[%0d]", w), qa[w+4], exp_q[w]);
    chk("rearm_done_count", 32'(fda), 2);
    // 10x10 float map with ~50% valid duty
    pxq.delete();
    for (int i = 0; i < 100; i++) pxq.push_back(rnd_px(0));
    build_exp(10, 0);
    c_start = 1;
    tick();
    c_start = 0;
    begin
      int idx = 0, cyc = 0;
      while (idx < 100 && cyc < 2000) begin
        if ($urandom_range(0, 1)) begin
          c_in = pxq[idx];
          c_valid = 1;
          idx++;
        end else begin
          c_in = $urandom;
          c_valid = 0;
        end
        tick();
        cyc++;
      end
      chk("map10_drive_budget", 32'(idx), 100);
    end
    c_valid = 0;
    repeat (3) tick();
    chk("map10_count", 32'(qc.size()), 25);
    for (int w = 0; w < 25; w++) chk($sformatf("map10_data[%0d]", w), qc[w], exp_q[w]);
    chk("map10_done_count", 32'(fdc), 1);
    chk("map10_busy", 32'(c_busy), 0);
    // asynchronous reset mid-map
    a_start = 1;
    tick();
    a_start = 0;
    for (int i = 0; i < 6; i++) begin
      a_in = i + 1;
      a_valid = 1;
      tick();
    end
    a_valid = 0;
    chk("pre_reset_valid", 32'(a_ov), 1);
    chk("pre_reset_data", a_out, 6);
    #2 reset = 0;
    #1;
    chk("async_rst_data", a_out, 0);
    chk("async_rst_valid", 32'(a_ov), 0);
    chk("async_rst_done", 32'(a_fd), 0);
    chk("async_rst_busy", 32'(a_busy), 0);
    tick();
    reset = 1;
    qa.delete();
    for (int i = 0; i < 8; i++) begin
      a_in = 32'h10 + i;
      a_valid = 1;
      tick();
    end
    a_valid = 0;
    repeat (2) tick();
    chk("post_rst_no_output", 32'(qa.size()), 0);
    chk("post_rst_busy", 32'(a_busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/maxpool_2x2_stream.md
# maxpool_2x2_stream

Streaming 2x2, stride-2 max-pooling stage that sits directly downstream of a convolution unit. It consumes one output-feature-map pixel per valid cycle in raster order, and emits one pooled pixel per 2x2 window. For LeNet5 conv2 this means a 10x10 map in and a 5x5 map out. A half-row line buffer of partial maxima lets the block run at full input rate without stalling.

## Interface
- DATA_WIDTH, 32, pixel width.
- ARITH_TYPE, 0, number format: 0 = IEEE-754 single (sign-magnitude compare), 1 = signed two's-complement fixed point.
- IFM_SIZE, 10, input map width and height. Must be even and ≥ 2.
- COL_BITS, $clog2(IFM_SIZE), width of the row and column counters.

- clk, input, 1, single clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-low; clears all state.
- start, input, 1, one-cycle pulse that arms the block for a new map.
- data_in, input, DATA_WIDTH, input pixel (e.g. unit_data_out of the conv unit).
- data_in_valid, input, 1, data_in is consumed this cycle.
- data_out, output, DATA_WIDTH, pooled pixel; holds its value between valids.
- data_out_valid, output, 1, one-cycle strobe marking data_out as new.
- frame_done, output, 1, one-cycle pulse when the last pooled pixel of the map is emitted.
- busy, output, 1, high while in RUN.

## Operation
- FSM has two states: IDLE and RUN.
  - IDLE → RUN on start. Row and column counters clear to 0.
  - RUN → IDLE on the cycle the pixel at (IFM_SIZE-1, IFM_SIZE-1) is consumed.
  - start while in RUN aborts the current map: counters clear, the line buffer is logically discarded, and the state stays RUN.
- data_in_valid in IDLE is ignored. No output is produced and no state changes.
- Each consumed pixel advances the column counter. At column IFM_SIZE-1 the column wraps to 0 and the row increments.
- Even row:
  - Even column: h_reg ← data_in.
  - Odd column: lb[col>>1] ← max(h_reg, data_in).
- Odd row:
  - Even column: h_reg ← data_in.
  - Odd column: data_out ← max(lb[col>>1], max(h_reg, data_in)), and data_out_valid is asserted.
- Line buffer lb has IFM_SIZE/2 entries of DATA_WIDTH bits, implemented as registers or distributed RAM.
  - It is written only on even rows and read only on odd rows, so no read/write collision is possible.
- max(a, b) rules:
  - ARITH_TYPE 1: signed compare.
  - ARITH_TYPE 0, signs differ: the positive value wins.
  - ARITH_TYPE 0, both non-negative: larger magnitude wins.
  - ARITH_TYPE 0, both negative: smaller magnitude wins.
  - ±0 compare equal.
  - On a tie the earlier-arriving operand (a) is kept. NaN/Inf are not handled.
- Output order is raster order over the pooled map: IFM_SIZE/2 × IFM_SIZE/2 results per map.

## Timing
- Reset values: data_out = 0, data_out_valid = 0, frame_done = 0, busy = 0, state = IDLE, counters = 0, h_reg = 0.
  - lb contents are don't-care, because every entry is written before it is read.
- Latency: data_out_valid rises one cycle after the edge that consumes the odd-row, odd-column pixel of a window (registered output).
- frame_done pulses in the same cycle as the final data_out_valid of the map.
- busy falls in the same cycle as frame_done.
- Throughput is one input per cycle with no backpressure. Gaps in data_in_valid are allowed anywhere and simply stretch the timing.
- start and data_in_valid in the same cycle: start wins and that pixel is discarded. The first pixel is taken on a later valid.
- start in the cycle the last pixel is consumed: frame_done still pulses, and the block re-arms in RUN with cleared counters.
- Reset deassertion mid-map: the block comes up in IDLE, and any partial window is lost.

## Test plan
- IFM_SIZE=4, ARITH_TYPE=1, start, then 16 back-to-back pixels 0..15 → data_out sequence 5, 7, 13, 15.
  - Each valid arrives one cycle after inputs 5, 7, 13 and 15 are consumed.
  - frame_done comes with the value 15.
- ARITH_TYPE=0, window {0xC0000000 (-2.0), 0xBF800000 (-1.0), 0xC0400000 (-3.0), 0xC0800000 (-4.0)} → 0xBF800000.
- ARITH_TYPE=0, window {0x80000000, 0x00000000, 0x80000000, 0x80000000} → 0x80000000 (tie keeps the first operand).
- IFM_SIZE=10, random data_in_valid gaps (~50% duty) over a full map → 25 outputs matching the reference model, and exactly one frame_done.
- data_in_valid while IDLE, then start mid-map after 7 pixels, then a full 16-pixel map (IFM_SIZE=4) → only the 4 outputs of the second map, all correct.
- Assert reset (low) mid-map → all outputs 0 immediately (asynchronously). After release, a data_in_valid without start produces no output.
